// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM host-side request sequencer.
// Address layout is {bank, row, col}.
package sdram_pkg;

    localparam int COL_W    = 10;
    localparam int ROW_W    = 13;
    localparam int BANK_W   = 2;
    localparam int ROW_LSB  = COL_W;
    localparam int BANK_LSB = ROW_LSB + ROW_W;
    localparam int ADDR_W   = BANK_LSB + BANK_W;
    localparam int DATA_W   = 16;

    localparam int REF_INTERVAL_DEF = 1500;
    localparam int MAX_OWED_DEF     = 8;
    localparam int DONE_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        S_WAIT_RDY,
        S_IDLE,
        S_OP,
        S_REF
    } seq_state_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh tick generator with a saturating count of refreshes
// that are due but not yet serviced.
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int MAX_OWED     = MAX_OWED_DEF
) (
    input  logic clk,
    input  logic reset_b,
    input  logic en,
    input  logic dec,
    output logic owed_nz,
    output logic overflow
);

    localparam int CW = $clog2(REF_INTERVAL);
    localparam int OW = $clog2(MAX_OWED + 1);

    logic [CW-1:0] cnt;
    logic [OW-1:0] owed;
    logic          reload;
    logic          sat;
    logic          inc;

    assign reload   = en && (cnt == '0);
    assign sat      = (owed == OW'(MAX_OWED));
    assign inc      = reload && !sat;
    assign overflow = reload && sat;
    assign owed_nz  = (owed != '0);

    // down-counter, frozen while the controller is not ready
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            cnt <= CW'(REF_INTERVAL - 1);
        end else if (en) begin
            cnt <= reload ? CW'(REF_INTERVAL - 1) : cnt - 1'b1;
        end
    end

    // owed count; a new tick and a serviced refresh in one cycle cancel
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            owed <= '0;
        end else if (inc && !dec) begin
            owed <= owed + 1'b1;
        end else if (dec && !inc && owed_nz) begin
            owed <= owed - 1'b1;
        end
    end

endmodule

// File: rtl/sdram_req_sequencer.sv
// Host request front end: serialises host read/write requests and
// periodic refreshes onto the controller's level request inputs.
module sdram_req_sequencer
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = REF_INTERVAL_DEF,
    parameter int MAX_OWED     = MAX_OWED_DEF,
    parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
    input  logic              clk_200MHz_i,
    input  logic              reset_bi,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic              req_ub_i,
    input  logic              req_lb_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_wr_o,
    output logic              err_o,
    input  logic              ctl_ready_i,
    input  logic              ctl_done_i,
    input  logic [DATA_W-1:0] ctl_data_i,
    output logic              ctl_rw_o,
    output logic              ctl_refresh_o,
    output logic              ctl_we_o,
    output logic [ADDR_W-1:0] ctl_addr_o,
    output logic [DATA_W-1:0] ctl_data_o,
    output logic              ctl_ub_o,
    output logic              ctl_lb_o
);

    localparam int TW = $clog2(DONE_TIMEOUT);
    localparam logic [TW-1:0] TMO_MAX = TW'(DONE_TIMEOUT - 1);

    seq_state_t        state, state_n;
    logic [TW-1:0]     tmo, tmo_n;
    logic              owed_nz, overflow, dec, tmo_hit;
    logic              rw_n, ref_n, we_n, ub_n, lb_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdat_n, rsp_d_n;
    logic              rsp_v_n, rsp_w_n, err_n;

    sdram_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL),
        .MAX_OWED    (MAX_OWED)
    ) u_ref (
        .clk     (clk_200MHz_i),
        .reset_b (reset_bi),
        .en      (ctl_ready_i),
        .dec     (dec),
        .owed_nz (owed_nz),
        .overflow(overflow)
    );

    assign req_ready_o = (state == S_IDLE) && !owed_nz && ctl_ready_i;

    // next state and next values of every registered output
    always_comb begin
        state_n = state;
        tmo_n   = tmo;
        rw_n    = ctl_rw_o;
        ref_n   = ctl_refresh_o;
        we_n    = ctl_we_o;
        addr_n  = ctl_addr_o;
        wdat_n  = ctl_data_o;
        ub_n    = ctl_ub_o;
        lb_n    = ctl_lb_o;
        rsp_v_n = 1'b0;
        rsp_d_n = rsp_data_o;
        rsp_w_n = rsp_wr_o;
        dec     = 1'b0;
        tmo_hit = 1'b0;
        if (!ctl_ready_i) begin
            state_n = S_WAIT_RDY;
            rw_n    = 1'b0;
            ref_n   = 1'b0;
            tmo_n   = '0;
        end else begin
            unique case (state)
                S_WAIT_RDY: state_n = S_IDLE;
                S_IDLE: begin
                    if (owed_nz) begin
                        ref_n   = 1'b1;
                        state_n = S_REF;
                    end else if (req_valid_i && req_ready_o) begin
                        rw_n    = 1'b1;
                        we_n    = req_we_i;
                        addr_n  = req_addr_i;
                        wdat_n  = req_data_i;
                        ub_n    = req_ub_i;
                        lb_n    = req_lb_i;
                        state_n = S_OP;
                    end
                end
                S_OP, S_REF: begin
                    if (ctl_done_i || tmo == TMO_MAX) begin
                        rw_n    = 1'b0;
                        ref_n   = 1'b0;
                        tmo_n   = '0;
                        state_n = S_IDLE;
                        dec     = (state == S_REF);
                        if (!ctl_done_i) begin
                            tmo_hit = 1'b1;
                        end else if (state == S_OP) begin
                            rsp_v_n = 1'b1;
                            rsp_w_n = ~ctl_we_o;
                            if (ctl_we_o) begin
                                rsp_d_n = ctl_data_i;
                            end
                        end
                    end else begin
                        tmo_n = tmo + 1'b1;
                    end
                end
                default: state_n = S_WAIT_RDY;
            endcase
        end
        err_n = err_o | overflow | tmo_hit;
    end

    // state register
    always_ff @(posedge clk_200MHz_i) begin
        if (!reset_bi) begin
            state <= S_WAIT_RDY;
        end else begin
            state <= state_n;
        end
    end

    // registered outputs and timeout timer
    always_ff @(posedge clk_200MHz_i) begin
        if (!reset_bi) begin
            tmo           <= '0;
            ctl_rw_o      <= 1'b0;
            ctl_refresh_o <= 1'b0;
            ctl_we_o      <= 1'b1;
            ctl_addr_o    <= '0;
            ctl_data_o    <= '0;
            ctl_ub_o      <= 1'b1;
            ctl_lb_o      <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= '0;
            rsp_wr_o      <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            tmo           <= tmo_n;
            ctl_rw_o      <= rw_n;
            ctl_refresh_o <= ref_n;
            ctl_we_o      <= we_n;
            ctl_addr_o    <= addr_n;
            ctl_data_o    <= wdat_n;
            ctl_ub_o      <= ub_n;
            ctl_lb_o      <= lb_n;
            rsp_valid_o   <= rsp_v_n;
            rsp_data_o    <= rsp_d_n;
            rsp_wr_o      <= rsp_w_n;
            err_o         <= err_n;
        end
    end

endmodule

// File: tb/tb_sdram_req_sequencer.sv
// Directed bench: dut_a runs default timing, dut_b a short refresh
// interval with a simple done responder for the interleave case.
`timescale 1ns/1ps
module tb_sdram_req_sequencer;

    logic        clk = 1'b0;
    logic        reset_bi;
    logic        req_valid, req_we, req_ub, req_lb, ctl_ready;
    logic [24:0] req_addr;
    logic [15:0] req_data;

    logic        done_a;
    logic [15:0] cdat_a;
    logic        rdy_a, rv_a, rw_a, err_a, crw_a, cref_a, cwe_a, cub_a, clb_a;
    logic [15:0] rd_a, cd_a;
    logic [24:0] ca_a;

    logic        done_b = 1'b0;
    logic [15:0] cdat_b;
    logic        rdy_b, rv_b, rw_b, err_b, crw_b, cref_b, cwe_b, cub_b, clb_b;
    logic [15:0] rd_b, cd_b;
    logic [24:0] ca_b;

    int vec = 0;
    int miss = 0;
    logic resp_en = 1'b0;
    int wcnt = 0;

    always #2.5 clk = ~clk;
    assign cdat_b = 16'hCAFE;

    sdram_req_sequencer dut_a (
        .clk_200MHz_i(clk), .reset_bi(reset_bi),
        .req_valid_i(req_valid), .req_ready_o(rdy_a),
        .req_we_i(req_we), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_ub_i(req_ub),
        .req_lb_i(req_lb), .rsp_valid_o(rv_a),
        .rsp_data_o(rd_a), .rsp_wr_o(rw_a), .err_o(err_a),
        .ctl_ready_i(ctl_ready), .ctl_done_i(done_a),
        .ctl_data_i(cdat_a), .ctl_rw_o(crw_a),
        .ctl_refresh_o(cref_a), .ctl_we_o(cwe_a),
        .ctl_addr_o(ca_a), .ctl_data_o(cd_a),
        .ctl_ub_o(cub_a), .ctl_lb_o(clb_a)
    );

    sdram_req_sequencer #(.REF_INTERVAL(20)) dut_b (
        .clk_200MHz_i(clk), .reset_bi(reset_bi),
        .req_valid_i(req_valid), .req_ready_o(rdy_b),
        .req_we_i(req_we), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_ub_i(req_ub),
        .req_lb_i(req_lb), .rsp_valid_o(rv_b),
        .rsp_data_o(rd_b), .rsp_wr_o(rw_b), .err_o(err_b),
        .ctl_ready_i(ctl_ready), .ctl_done_i(done_b),
        .ctl_data_i(cdat_b), .ctl_rw_o(crw_b),
        .ctl_refresh_o(cref_b), .ctl_we_o(cwe_b),
        .ctl_addr_o(ca_b), .ctl_data_o(cd_b),
        .ctl_ub_o(cub_b), .ctl_lb_o(clb_b)
    );

    // controller stand-in for dut_b: done three cycles into each request
    always @(posedge clk) begin
        if (!resp_en || done_b) begin
            done_b <= 1'b0;
            wcnt   <= 0;
        end else if (crw_b || cref_b) begin
            if (wcnt == 2) done_b <= 1'b1;
            else wcnt <= wcnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int nref, nrd, nrsp, last_op;
        logic prev_rw, prev_ref;
        reset_bi  = 1'b0;
        ctl_ready = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b1;
        req_ub    = 1'b1;
        req_lb    = 1'b1;
        req_addr  = '0;
        req_data  = '0;
        done_a    = 1'b0;
        cdat_a    = '0;
        tick();
        tick();
        chk("rst_ready", rdy_a, 0);
        chk("rst_rsp_valid", rv_a, 0);
        chk("rst_rsp_data", rd_a, 0);
        chk("rst_rsp_wr", rw_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_rw", crw_a, 0);
        chk("rst_refresh", cref_a, 0);
        chk("rst_we", cwe_a, 1);
        chk("rst_addr", ca_a, 0);
        chk("rst_data", cd_a, 0);
        chk("rst_ub", cub_a, 1);
        chk("rst_lb", clb_a, 1);

        // 1: controller not ready blocks the host
        reset_bi  = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_ub    = 1'b0;
        req_lb    = 1'b0;
        req_addr  = 25'h1A0_0123;
        req_data  = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_ready", rdy_a, 0);
            chk("t1_rw", crw_a, 0);
        end

        // 2: write, fields held until done
        ctl_ready = 1'b1;
        tick();
        chk("t2_ready_idle", rdy_a, 1);
        tick();
        chk("t2_rw", crw_a, 1);
        chk("t2_we", cwe_a, 0);
        chk("t2_addr", ca_a, 25'h1A0_0123);
        chk("t2_data", cd_a, 16'hBEEF);
        chk("t2_ub", cub_a, 0);
        chk("t2_lb", clb_a, 0);
        chk("t2_ready_busy", rdy_a, 0);
        chk("t2_no_ref", cref_a, 0);
        req_valid = 1'b0;
        req_addr  = 25'h0;
        req_data  = 16'h0;
        req_we    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_hold_rw", crw_a, 1);
            chk("t2_hold_addr", ca_a, 25'h1A0_0123);
            chk("t2_hold_data", cd_a, 16'hBEEF);
            chk("t2_no_rsp", rv_a, 0);
        end
        done_a = 1'b1;
        cdat_a = 16'h7777;
        tick();
        done_a = 1'b0;
        chk("t2_rw_drop", crw_a, 0);
        chk("t2_rsp_valid", rv_a, 1);
        chk("t2_rsp_wr", rw_a, 1);
        chk("t2_rsp_data", rd_a, 0);
        tick();
        chk("t2_rsp_pulse", rv_a, 0);
        chk("t2_rw_idle", crw_a, 0);

        // 3: read returns data sampled in the done cycle
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 25'h000_0456;
        tick();
        req_valid = 1'b0;
        chk("t3_rw", crw_a, 1);
        chk("t3_we", cwe_a, 1);
        chk("t3_addr", ca_a, 25'h000_0456);
        tick();
        cdat_a = 16'h5A5A;
        done_a = 1'b1;
        tick();
        done_a = 1'b0;
        cdat_a = 16'h1234;
        chk("t3_rsp_valid", rv_a, 1);
        chk("t3_rsp_data", rd_a, 16'h5A5A);
        chk("t3_rsp_wr", rw_a, 0);
        chk("t3_rw_drop", crw_a, 0);
        tick();
        chk("t3_rsp_pulse", rv_a, 0);
        chk("t3_data_held", rd_a, 16'h5A5A);

        // 5: no done -> timeout after 64 cycles
        req_valid = 1'b1;
        req_addr  = 25'h000_0077;
        tick();
        req_valid = 1'b0;
        chk("t5_rw", crw_a, 1);
        repeat (63) tick();
        chk("t5_err_early", err_a, 0);
        chk("t5_rw_early", crw_a, 1);
        tick();
        chk("t5_err", err_a, 1);
        chk("t5_rw_drop", crw_a, 0);
        chk("t5_no_rsp", rv_a, 0);
        chk("t5_idle", rdy_a, 1);
        tick();
        chk("t5_err_sticky", err_a, 1);
        chk("t5_no_rsp2", rv_a, 0);

        // 6: reset during an operation
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 25'h000_0155;
        req_data  = 16'hA5A5;
        tick();
        req_valid = 1'b0;
        chk("t6_rw", crw_a, 1);
        tick();
        reset_bi = 1'b0;
        tick();
        chk("t6_rw", crw_a, 0);
        chk("t6_we", cwe_a, 1);
        chk("t6_addr", ca_a, 0);
        chk("t6_data", cd_a, 0);
        chk("t6_ub", cub_a, 1);
        chk("t6_lb", clb_a, 1);
        chk("t6_err", err_a, 0);
        chk("t6_rsp_valid", rv_a, 0);
        chk("t6_rsp_data", rd_a, 0);
        chk("t6_ready_wait", rdy_a, 0);
        reset_bi = 1'b1;
        tick();
        chk("t6_ready_idle", rdy_a, 1);

        // 4: refresh interleaved with continuous reads on dut_b
        reset_bi = 1'b0;
        tick();
        reset_bi  = 1'b1;
        resp_en   = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 25'h0AB_CDEF;
        nref = 0;
        nrd = 0;
        nrsp = 0;
        last_op = 0;
        prev_rw = 1'b0;
        prev_ref = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("t4_exclusive", {31'b0, crw_b & cref_b}, 0);
            if (cref_b && !prev_ref) begin
                chk("t4_ref_after_read", last_op, 1);
                last_op = 2;
                nref++;
            end
            if (crw_b && !prev_rw) begin
                last_op = 1;
                nrd++;
            end
            if (rv_b) begin
                nrsp++;
                chk("t4_rsp_data", rd_b, 16'hCAFE);
                chk("t4_rsp_wr", rw_b, 0);
            end
            prev_rw  = crw_b;
            prev_ref = cref_b;
        end
        req_valid = 1'b0;
        chk("t4_nref_lo", {31'b0, nref >= 13}, 1);
        chk("t4_nref_hi", {31'b0, nref <= 15}, 1);
        chk("t4_rsp_cnt", {31'b0, nrsp >= nrd - 1 && nrsp <= nrd}, 1);
        chk("t4_err", err_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
